// File: rtl/fm_pkg.sv
// Shared definitions for the FM operator sequencer.
// State encodings, tremolo constants and the tremolo shaping function.
package fm_pkg;

    localparam int NUM_OPS_DEF     = 36;
    localparam int AM_DIV_BITS_DEF = 6;

    localparam logic [7:0] TREM_STEPS = 8'd210;
    localparam logic [7:0] TREM_HALF  = 8'd105;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ADDR   = 2'd1;
    localparam logic [1:0] ST_READ   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    // Triangle fold of the position, then scaled down by depth
    function automatic logic [5:0] am_calc(
        input logic [7:0] pos,
        input logic       deep
    );
        logic [7:0] raw;
        raw = (pos < TREM_HALF) ? pos : (TREM_STEPS - 8'd1 - pos);
        return deep ? raw[7:2] : {2'b00, raw[7:4]};
    endfunction

endpackage

// File: rtl/fm_op_seq_trem.sv
// Tremolo generator: sweep-rate divider, triangle position and
// registered attenuation offset that only moves while the sequencer idles.
module fm_trem
    import fm_pkg::*;
#(
    parameter int AM_DIV_BITS = AM_DIV_BITS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       upd_en,
    input  logic       am_depth,
    output logic [5:0] am_val
);

    logic [AM_DIV_BITS-1:0] div;
    logic [7:0]             trem_pos;

    always_ff @(posedge clk) begin
        if (reset) begin
            div      <= '0;
            trem_pos <= 8'd0;
            am_val   <= 6'd0;
        end else begin
            if (step) begin
                div <= div + AM_DIV_BITS'(1);
                if (&div) begin
                    trem_pos <= (trem_pos == TREM_STEPS - 8'd1)
                              ? 8'd0 : trem_pos + 8'd1;
                end
            end
            if (upd_en) begin
                am_val <= am_calc(trem_pos, am_depth);
            end
        end
    end

endmodule

// File: rtl/fm_op_seq.sv
// Operator sweep sequencer: walks op_sel through ADDR/READ/COMMIT per slot,
// tracks deferred operator-reset requests and drives the tremolo step.
module fm_op_seq
    import fm_pkg::*;
#(
    parameter int NUM_OPS     = NUM_OPS_DEF,
    parameter int AM_DIV_BITS = AM_DIV_BITS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       reset_req,
    input  logic       am_depth,
    output logic [5:0] op_sel,
    output logic       next,
    output logic       op_reset,
    output logic [5:0] am_val,
    output logic       busy,
    output logic       sweep_done,
    output logic       overrun
);

    localparam logic [5:0] LAST_OP = 6'(NUM_OPS - 1);

    logic [1:0] state;
    logic       pend;
    logic       act;
    logic       last;

    assign last = (op_sel == LAST_OP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_sel     <= 6'd0;
            next       <= 1'b0;
            op_reset   <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            overrun    <= 1'b0;
            pend       <= 1'b0;
            act        <= 1'b0;
        end else begin
            next       <= 1'b0;
            op_reset   <= 1'b0;
            sweep_done <= 1'b0;
            if (sample_tick && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            if (reset_req) begin
                pend <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (sample_tick) begin
                        state  <= ST_ADDR;
                        op_sel <= 6'd0;
                        busy   <= 1'b1;
                        // a request in the tick cycle joins this sweep
                        act    <= pend | reset_req;
                        pend   <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    state <= ST_READ;
                end
                ST_READ: begin
                    state    <= ST_COMMIT;
                    next     <= 1'b1;
                    op_reset <= act;
                    if (last) begin
                        busy       <= 1'b0;
                        sweep_done <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (last) begin
                        state <= ST_IDLE;
                        act   <= 1'b0;
                    end else begin
                        state  <= ST_ADDR;
                        op_sel <= op_sel + 6'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fm_trem #(
        .AM_DIV_BITS(AM_DIV_BITS)
    ) u_trem (
        .clk     (clk),
        .reset   (reset),
        .step    (sweep_done),
        .upd_en  (state == ST_IDLE),
        .am_depth(am_depth),
        .am_val  (am_val)
    );

endmodule

// File: tb/tb_fm_op_seq.sv
// Directed bench for fm_op_seq: full-size sweeps on one instance,
// tremolo sweep-count checks on a shrunk instance.
module tb_fm_op_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, tick0, rr0, dep0;
    logic [5:0] op_sel0, am0;
    logic       nx0, ors0, busy0, sd0, ovr0;

    logic       rst1, tick1, rr1, dep1;
    logic [5:0] op_sel1, am1;
    logic       nx1, ors1, busy1, sd1, ovr1;

    fm_op_seq u0 (
        .clk(clk), .reset(rst0), .sample_tick(tick0), .reset_req(rr0),
        .am_depth(dep0), .op_sel(op_sel0), .next(nx0), .op_reset(ors0),
        .am_val(am0), .busy(busy0), .sweep_done(sd0), .overrun(ovr0)
    );

    fm_op_seq #(.NUM_OPS(1), .AM_DIV_BITS(2)) u1 (
        .clk(clk), .reset(rst1), .sample_tick(tick1), .reset_req(rr1),
        .am_depth(dep1), .op_sel(op_sel1), .next(nx1), .op_reset(ors1),
        .am_val(am1), .busy(busy1), .sweep_done(sd1), .overrun(ovr1)
    );

    int total = 0;
    int bad   = 0;
    bit exp_ovr = 1'b0;

    typedef struct {
        bit rq0;
        int tick_at;
        int rq_at;
        bit exp_rst;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // bundle = {busy, next, op_reset, sweep_done, overrun, op_sel}
    function automatic logic [10:0] pack0();
        return {busy0, nx0, ors0, sd0, ovr0, op_sel0};
    endfunction

    task automatic run_sweep(input bit rq0, input int tick_at,
                             input int rq_at, input bit exp_rst, input int id);
        logic [10:0] e;
        logic [5:0]  es;
        bit          en;
        @(negedge clk);
        tick0 = 1'b1;
        rr0   = rq0;
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk);
            if (tick_at != 0 && c == tick_at + 1) exp_ovr = 1'b1;
            en = (c % 3 == 0) && (c <= 108);
            es = (c <= 108) ? 6'((c - 1) / 3) : 6'd35;
            e  = {(c <= 107), en, en & exp_rst, (c == 108), exp_ovr, es};
            chk($sformatf("sweep%0d_c%0d", id, c), 32'(pack0()), 32'(e));
            tick0 = (c == tick_at);
            rr0   = (c == rq_at);
        end
        tick0 = 1'b0;
        rr0   = 1'b0;
    endtask

    task automatic trem_sweeps(input int n);
        int k;
        for (int s = 0; s < n; s++) begin
            tick1 = 1'b1;
            @(negedge clk);
            tick1 = 1'b0;
            k = 0;
            while (!sd1 && k < 10) begin
                @(negedge clk);
                k++;
            end
            if (!sd1) begin
                chk("trem_timeout", 32'(sd1), 32'd1);
                return;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{1'b0, 0,  0,  1'b0};
        tbl[1] = '{1'b0, 50, 0,  1'b0};
        tbl[2] = '{1'b0, 0,  20, 1'b0};
        tbl[3] = '{1'b0, 0,  0,  1'b1};
        tbl[4] = '{1'b0, 0,  0,  1'b0};
        tbl[5] = '{1'b1, 0,  0,  1'b1};
        tbl[6] = '{1'b0, 0,  0,  1'b0};

        rst0 = 1'b1; tick0 = 1'b0; rr0 = 1'b0; dep0 = 1'b0;
        rst1 = 1'b1; tick1 = 1'b0; rr1 = 1'b0; dep1 = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_u0", {21'd0, pack0()}, 32'd0);
        chk("reset_am0", 32'(am0), 32'd0);
        chk("reset_am1", 32'(am1), 32'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        foreach (tbl[i]) begin
            run_sweep(tbl[i].rq0, tbl[i].tick_at, tbl[i].rq_at,
                      tbl[i].exp_rst, i);
        end

        // reset_req at cycle 20, reset at cycle 40 of a sweep
        @(negedge clk);
        tick0 = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c >= 41) begin
                chk($sformatf("abort_c%0d", c), 32'(pack0()), 32'd0);
            end
            tick0 = 1'b0;
            rr0   = (c == 19);
            rst0  = (c == 39);
        end
        exp_ovr = 1'b0;
        run_sweep(1'b0, 0, 0, 1'b0, 99);

        // tremolo: 4 sweeps per step on the shrunk instance
        trem_sweeps(200);
        chk("trem_pos50_deep", 32'(am1), 32'd12);
        trem_sweeps(220);
        chk("trem_peak_deep", 32'(am1), 32'd26);
        trem_sweeps(420);
        chk("trem_wrap_zero", 32'(am1), 32'd0);
        dep1 = 1'b0;
        trem_sweeps(420);
        chk("trem_peak_shallow", 32'(am1), 32'd6);
        dep1 = 1'b1;
        repeat (2) @(negedge clk);
        chk("trem_depth_switch", 32'(am1), 32'd26);
        trem_sweeps(4);
        chk("trem_pos106_deep", 32'(am1), 32'd25);
        chk("trem_no_overrun", 32'(ovr1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fm_op_seq.md
FM_OP_SEQ -- requirements
Module: fm_op_seq

Interface
REQ-001 Parameter NUM_OPS, default 36, number of operator slots swept per sample.
REQ-002 Parameter AM_DIV_BITS, default 6, log2 of samples per tremolo step.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 sample_tick  input  1  one-cycle pulse that starts an operator sweep.
REQ-006 reset_req  input  1  one-cycle pulse requesting that all operators be forced to release at max attenuation.
REQ-007 am_depth  input  1  tremolo depth: 0 = shallow, 1 = deep.
REQ-008 op_sel  output  6  operator index presented to the parameter and envelope-state RAMs.
REQ-009 next  output  1  one-cycle write strobe committing the envelope state for op_sel.
REQ-010 op_reset  output  1  level, valid while next=1; forces the selected operator to release at max attenuation.
REQ-011 am_val  output  6  tremolo attenuation offset, constant for a whole sweep.
REQ-012 busy  output  1  high while a sweep is in progress.
REQ-013 sweep_done  output  1  one-cycle pulse after the last operator is committed.
REQ-014 overrun  output  1  sticky flag; set when sample_tick arrives while busy.

Function
REQ-015 FSM states: IDLE, ADDR, READ, COMMIT.
REQ-016 IDLE -> ADDR on sample_tick; op_sel <= 0 and busy <= 1 in the same edge.
REQ-017 ADDR lasts 1 cycle and lets the registered RAM reads at op_sel complete; it is followed by READ.
REQ-018 READ lasts 1 cycle; read data is valid and the envelope datapath settles; it is followed by COMMIT.
REQ-019 COMMIT lasts 1 cycle with next=1 and op_sel unchanged.
REQ-020 From COMMIT the FSM goes to ADDR with op_sel+1 if op_sel < NUM_OPS-1; otherwise it goes to IDLE, pulses sweep_done and drops busy.
REQ-021 Each operator takes exactly 3 cycles; a full sweep takes 3*NUM_OPS cycles (108 at default) from the tick to the sweep_done cycle inclusive.
REQ-022 op_sel never exceeds NUM_OPS-1 and never wraps within a sweep.
REQ-023 next is 0 in every state except COMMIT.
REQ-024 A sample_tick while busy is ignored, sets overrun, and does not restart or extend the sweep.
REQ-025 overrun clears only on reset.
REQ-026 reset_req sets a pending flag.
REQ-027 At the sample_tick that starts a sweep, the pending flag transfers to an active flag and is cleared.
REQ-028 While the active flag is set, op_reset=1 on every COMMIT of that sweep; the active flag clears at sweep_done.
REQ-029 A reset_req arriving mid-sweep does not affect the current sweep; it applies to the next sweep.
REQ-030 A reset_req in the same cycle as the starting sample_tick applies to that sweep.
REQ-031 Tremolo: a divider of AM_DIV_BITS bits increments at each sweep_done.
REQ-032 Tremolo: on divider wrap, trem_pos (8 bits, range 0..209) increments and wraps from 209 to 0.
REQ-033 am_raw = trem_pos when trem_pos < 105, otherwise 209 - trem_pos (range 0..104).
REQ-034 am_val = am_raw >> 2 when am_depth=1 (range 0..26), otherwise am_raw >> 4 (range 0..6).
REQ-035 am_val is registered and updates only in IDLE; it is stable for the whole sweep.
REQ-036 An am_depth change is reflected in am_val on the next cycle spent in IDLE.

Reset
REQ-037 On reset, in the same edge: FSM = IDLE; op_sel, next, op_reset, busy, sweep_done, overrun = 0; pending and active flags = 0; divider, trem_pos, am_val = 0.
REQ-038 Reset asserted mid-sweep aborts the sweep immediately, produces no further next, and produces no sweep_done.

Structure
REQ-039 NUM_OPS default, the state encodings, TREM_STEPS=210 and TREM_HALF=105 are defined in the shared fm package.
REQ-040 The tremolo generator is a sub-module named fm_trem (inputs: step strobe, am_depth; output: am_val); the rest is flat.

Verification
REQ-041 Scenario: single sample_tick after reset -> next pulses on cycles 3,6,...,108 with op_sel 0..35; sweep_done on cycle 108; busy high on cycles 1..107 after the tick.
REQ-042 Scenario: sample_tick at cycle 50 of a sweep -> overrun=1; sweep still ends at cycle 108; no second sweep starts.
REQ-043 Scenario: reset_req mid-sweep -> op_reset=0 for the rest of that sweep; op_reset=1 on all 36 next pulses of the following sweep; op_reset=0 on the sweep after that.
REQ-044 Scenario: am_depth=1 and 64*105 sweeps -> am_val reaches 26; after 64*210 sweeps am_val returns to 0; with am_depth=0 the peak is 6.
REQ-045 Scenario: reset asserted at cycle 40 of a sweep -> all outputs 0 on the next cycle; the next sample_tick starts at op_sel=0.
REQ-046 Scenario: reset_req and sample_tick in the same cycle -> op_reset=1 on all 36 commits of that sweep.
